// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one variable-latency memory between
// instruction fetch and MEM-stage data access, and generates pipeline stalls.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;
    typedef enum logic {GRANT_DATA, GRANT_FETCH} grant_t;

    state_t state, state_nxt;
    grant_t last_grant;
    logic   dm_pend;
    logic   grant_dm;
    logic   grant_if;
    logic   ack_data;
    logic   ack_fetch;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            last_grant <= GRANT_FETCH;
        end else begin
            state <= state_nxt;
            if (ack_data)
                last_grant <= GRANT_DATA;
            else if (ack_fetch)
                last_grant <= GRANT_FETCH;
        end
    end

    // On a tie, data wins unless it was the last requester served.
    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        ack_data  = 1'b0;
        ack_fetch = 1'b0;
        unique case (state)
            IDLE: begin
                grant_dm = dm_pend & (~if_req_i | (last_grant == GRANT_FETCH));
                grant_if = if_req_i & ~grant_dm;
                if (grant_dm)
                    state_nxt = DATA;
                else if (grant_if)
                    state_nxt = FETCH;
            end
            DATA: begin
                ack_data = mem_ack_i;
                if (mem_ack_i)
                    state_nxt = DONE;
            end
            FETCH: begin
                ack_fetch = mem_ack_i;
                if (mem_ack_i)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dm_pend     = dm_read_i | dm_write_i;
        stall_mem_o = dm_pend & ~dm_ready_o;
        stall_if_o  = (if_req_i & ~if_ready_o) | stall_mem_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            if_ready_o  <= 1'b0;
            dm_ready_o  <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if_ready_o <= 1'b0;
            dm_ready_o <= 1'b0;
            if (grant_dm) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= dm_write_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
            end else if (grant_if) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= '0;
            end
            if (ack_data) begin
                mem_req_o  <= 1'b0;
                dm_ready_o <= 1'b1;
                if (!mem_we_o)
                    dm_rdata_o <= mem_rdata_i;
            end
            if (ack_fetch) begin
                mem_req_o  <= 1'b0;
                if_ready_o <= 1'b1;
                if_rdata_o <= mem_rdata_i;
            end
            if ((stall_if_o | stall_mem_o) && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timing model
// built from grant cycle, wait count and the round-robin rule.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] stall_cnt;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Model: a transaction granted at cycle g with w wait cycles has
    // mem_req over [g+1, g+1+w], ready at g+2+w, arbiter free at g+3+w.
    int          cyc;
    int          g;
    int          w;
    bit          busy;
    bit          cur_fetch;
    bit          last_fetch;
    bit          s_we;
    bit          force_ack;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] ack_data;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
    logic [31:0] exp_cnt;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_ready_o (if_ready),
        .dm_read_i  (dm_read),
        .dm_write_i (dm_write),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_rdata_o (dm_rdata),
        .dm_ready_o (dm_ready),
        .stall_if_o (stall_if),
        .stall_mem_o(stall_mem),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_reset_zero(input string tag);
        check_eq({tag, ".mem_req"},   32'(mem_req),   32'd0);
        check_eq({tag, ".mem_we"},    32'(mem_we),    32'd0);
        check_eq({tag, ".mem_addr"},  mem_addr,       32'd0);
        check_eq({tag, ".mem_wdata"}, mem_wdata,      32'd0);
        check_eq({tag, ".if_rdata"},  if_rdata,       32'd0);
        check_eq({tag, ".dm_rdata"},  dm_rdata,       32'd0);
        check_eq({tag, ".if_ready"},  32'(if_ready),  32'd0);
        check_eq({tag, ".dm_ready"},  32'(dm_ready),  32'd0);
        check_eq({tag, ".stall_cnt"}, stall_cnt,      32'd0);
    endtask

    task automatic model_reset();
        cyc          = 0;
        busy         = 1'b0;
        last_fetch   = 1'b1;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        exp_cnt      = '0;
    endtask

    task automatic clear_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic new_dm_req();
        int unsigned kind;
        kind     = $urandom_range(0, 2);
        dm_read  = (kind != 1);
        dm_write = (kind != 0);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
    endtask

    // Entered just after a rising edge; each iteration is one clock cycle.
    task automatic run(input int n, input bit both_first);
        for (int i = 0; i < n; i++) begin
            bit exp_req;
            bit exp_ifr;
            bit exp_dmr;
            bit dm_pend;
            bit exp_smem;
            bit exp_sif;

            if (busy && cyc == g + 3 + w) begin
                busy = 1'b0;
                if (cur_fetch)
                    if_req = 1'b0;
                else begin
                    dm_read  = 1'b0;
                    dm_write = 1'b0;
                end
            end

            if (i == 0 && both_first) begin
                if_req  = 1'b1;
                if_addr = $urandom;
                new_dm_req();
            end else begin
                if (!if_req && $urandom_range(0, 1) == 0) begin
                    if_req  = 1'b1;
                    if_addr = $urandom;
                end
                if (!(dm_read | dm_write) && $urandom_range(0, 2) == 0)
                    new_dm_req();
                if ($urandom_range(0, 3) == 0)
                    if_addr = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    dm_addr  = $urandom;
                    dm_wdata = $urandom;
                end
            end

            dm_pend = dm_read | dm_write;
            if (!busy && (dm_pend || if_req)) begin
                cur_fetch  = if_req && (!dm_pend || !last_fetch);
                busy       = 1'b1;
                g          = cyc;
                w          = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
                s_addr     = cur_fetch ? if_addr : dm_addr;
                s_wdata    = dm_wdata;
                s_we       = !cur_fetch && dm_write;
                ack_data   = $urandom;
                last_fetch = cur_fetch;
            end

            exp_req = busy && cyc >= g + 1 && cyc <= g + 1 + w;
            if (busy && cyc == g + 1 + w) begin
                mem_ack   = 1'b1;
                mem_rdata = ack_data;
            end else if (exp_req) begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end else begin
                mem_ack   = (i == 0 && force_ack) || ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end

            exp_ifr = busy && cur_fetch && cyc == g + 2 + w;
            exp_dmr = busy && !cur_fetch && cyc == g + 2 + w;
            if (exp_ifr)
                exp_if_rdata = ack_data;
            if (exp_dmr && !s_we)
                exp_dm_rdata = ack_data;
            exp_smem = dm_pend && !exp_dmr;
            exp_sif  = (if_req && !exp_ifr) || exp_smem;

            @(negedge clk);
            check_eq("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                check_eq("mem_addr", mem_addr, s_addr);
                check_eq("mem_we", 32'(mem_we), 32'(s_we));
                if (!cur_fetch)
                    check_eq("mem_wdata", mem_wdata, s_wdata);
            end
            check_eq("if_ready", 32'(if_ready), 32'(exp_ifr));
            check_eq("dm_ready", 32'(dm_ready), 32'(exp_dmr));
            check_eq("if_rdata", if_rdata, exp_if_rdata);
            check_eq("dm_rdata", dm_rdata, exp_dm_rdata);
            check_eq("stall_mem", 32'(stall_mem), 32'(exp_smem));
            check_eq("stall_if", 32'(stall_if), 32'(exp_sif));
            check_eq("stall_cnt", stall_cnt, exp_cnt);
            if (exp_sif || exp_smem)
                exp_cnt = exp_cnt + 32'd1;

            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst       = 1'b0;
        force_ack = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check_reset_zero("reset");
        check_eq("reset.stall_if", 32'(stall_if), 32'd0);
        if_req  = 1'b1;
        dm_read = 1'b1;
        #1;
        check_eq("reset.stall_if_comb", 32'(stall_if), 32'd1);
        check_eq("reset.stall_mem_comb", 32'(stall_mem), 32'd1);
        clear_inputs();

        @(posedge clk);
        #1;
        rst = 1'b1;
        run(400, 1'b1);

        // Abandon a data read while its ack is still outstanding.
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        dm_read = 1'b1;
        dm_addr = 32'h0000_2000;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mid.mem_req", 32'(mem_req), 32'd1);
        check_eq("mid.mem_addr", mem_addr, 32'h0000_2000);
        check_eq("mid.stall_mem", 32'(stall_mem), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_zero("mid_reset");
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        force_ack = 1'b1;
        run(400, 1'b1);
        force_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
